// File: rtl/salu_issue_ctrl_if.sv
// salu_issue_ctrl_if: pipeline request, CLO/CLZ unit and writeback signals of the issue controller
interface salu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              req_valid;
    logic              req_clo;
    logic              req_clz;
    logic [DATA_W-1:0] req_operand;
    logic [REG_W-1:0]  req_dst;
    logic              req_ready;
    logic              stall;
    logic              unit_clo;
    logic              unit_clz;
    logic [DATA_W-1:0] unit_operand;
    logic              unit_busy;
    logic [DATA_W-1:0] unit_result;
    logic              unit_flush;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              timeout_err;

    modport master (
        input  flush, req_valid, req_clo, req_clz, req_operand, req_dst,
        input  unit_busy, unit_result, wb_ready,
        output req_ready, stall, unit_clo, unit_clz, unit_operand, unit_flush,
        output wb_valid, wb_dst, wb_data, timeout_err
    );

    modport slave (
        output flush, req_valid, req_clo, req_clz, req_operand, req_dst,
        output unit_busy, unit_result, wb_ready,
        input  req_ready, stall, unit_clo, unit_clz, unit_operand, unit_flush,
        input  wb_valid, wb_dst, wb_data, timeout_err
    );
endinterface

// File: rtl/salu_issue_ctrl.sv
// salu_issue_ctrl: EX-stage issue, stall and writeback controller for the iterative CLO/CLZ unit
module salu_issue_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 40
) (
    input logic               clk,
    input logic               reset,
    salu_issue_ctrl_if.master bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              unit_clo;
    logic              unit_clz;
    logic              wb_valid;
    logic              timeout_err;
    logic [DATA_W-1:0] unit_operand;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_dst;
    logic              req_ready;

    assign req_ready        = state == IDLE && !bus.flush && !reset;
    assign bus.req_ready    = req_ready;
    assign bus.stall        = state != IDLE || (bus.req_valid && !req_ready);
    assign bus.unit_flush   = reset || bus.flush || timeout_err;
    assign bus.unit_clo     = unit_clo;
    assign bus.unit_clz     = unit_clz;
    assign bus.unit_operand = unit_operand;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_dst       = wb_dst;
    assign bus.wb_data      = wb_data;
    assign bus.timeout_err  = timeout_err;

    // Sequencer: one-cycle launch pulse, skip the busy-rise cycle, wait with watchdog, hold writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            unit_clo     <= 1'b0;
            unit_clz     <= 1'b0;
            unit_operand <= '0;
            wb_valid     <= 1'b0;
            wb_dst       <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            unit_clo    <= 1'b0;
            unit_clz    <= 1'b0;
            timeout_err <= 1'b0;
            if (bus.flush) begin
                state    <= IDLE;
                wb_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.req_valid) begin
                        unit_operand <= bus.req_operand;
                        wb_dst       <= bus.req_dst;
                        if (bus.req_clo || bus.req_clz) begin
                            unit_clo <= bus.req_clo;
                            unit_clz <= bus.req_clz && !bus.req_clo;
                            state    <= LAUNCH;
                        end else begin
                            wb_data  <= '0;
                            wb_valid <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    LAUNCH: state <= ARM;
                    ARM: begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                    WAIT: if (!bus.unit_busy) begin
                        wb_data  <= bus.unit_result;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(MAX_WAIT - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    DONE: if (bus.wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_salu_issue_ctrl.sv
// tb_salu_issue_ctrl: vector table plus corner sequences against a CLO/CLZ unit model and writeback scoreboard
module tb_salu_issue_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int MW = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    salu_issue_ctrl_if #(.DATA_W(DW), .REG_W(RW)) bus ();

    salu_issue_ctrl #(.DATA_W(DW), .REG_W(RW), .MAX_WAIT(MW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [RW-1:0] dst;
        logic [DW-1:0] data;
    } wb_t;

    typedef struct {
        logic          clo;
        logic          clz;
        logic [DW-1:0] op;
        logic [RW-1:0] dst;
        int            lat;
        int            hold;
        logic [DW-1:0] want;
    } vec_t;

    wb_t  q[$];
    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;
    int   clo_hi = 0;
    int   clz_hi = 0;
    int   to_hi = 0;
    int   uf_hi = 0;
    int   hs = 0;
    int   lat_cfg = 2;
    bit   hang = 1'b0;
    int   rem = 0;
    logic [DW-1:0] res = '0;

    function automatic logic [DW-1:0] lead(input logic [DW-1:0] x, input logic ones);
        int n = 0;
        for (int i = DW - 1; i >= 0 && x[i] == ones; i--) n++;
        return DW'(n);
    endfunction

    assign bus.unit_busy   = rem != 0;
    assign bus.unit_result = res;

    // Unit model: busy rises the cycle after launch and stays high for lat_cfg cycles (forever when hung)
    always @(posedge clk) begin
        if (bus.unit_flush) rem <= 0;
        else if (bus.unit_clo || bus.unit_clz) begin
            rem <= lat_cfg;
            res <= lead(bus.unit_operand, bus.unit_clo);
        end else if (rem != 0 && !hang) rem <= rem - 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: pulse accounting and scoreboard pop on every writeback handshake
    always @(negedge clk) begin
        wb_t e;
        if (bus.unit_clo) clo_hi++;
        if (bus.unit_clz) clz_hi++;
        if (bus.timeout_err) to_hi++;
        if (bus.unit_flush) uf_hi++;
        if (bus.unit_clo && bus.unit_clz) begin
            fails++;
            $display("FAIL launch_both: unit_clo and unit_clz high together");
        end
        if (bus.wb_valid && bus.wb_ready && !bus.flush && !reset) begin
            hs++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got dst %0d data 0x%0h, expected no writeback", bus.wb_dst, bus.wb_data);
            end else begin
                e = q.pop_front();
                check("wb_dst", 32'(bus.wb_dst), 32'(e.dst));
                check("wb_data", bus.wb_data, e.data);
            end
        end
    end

    task automatic issue(input logic clo, input logic clz, input logic [DW-1:0] op, input logic [RW-1:0] dst,
                         input logic [DW-1:0] want, input bit push);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_clo = clo;
        bus.req_clz = clz;
        bus.req_operand = op;
        bus.req_dst = dst;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(bus.req_ready), 1);
        if (push) q.push_back('{dst, want});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_wb();
        int n = 0;
        @(negedge clk);
        while (!bus.wb_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wb_arrives", 32'(bus.wb_valid), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 1;
        int c0 = clo_hi;
        int z0 = clz_hi;
        int h0 = hs;
        bit st = 1'b1;
        lat_cfg = v.lat;
        bus.wb_ready = v.hold == 0;
        issue(v.clo, v.clz, v.op, v.dst, v.want, 1'b1);
        @(negedge clk);
        while (!bus.wb_valid && n < 100) begin
            st &= bus.stall;
            @(negedge clk);
            n++;
        end
        check("latency", n, (v.clo || v.clz) ? 3 + v.lat : 1);
        check("stall_busy", 32'(st), 1);
        for (int i = 0; i < v.hold; i++) begin
            check("hold_valid", 32'(bus.wb_valid), 1);
            check("hold_dst", 32'(bus.wb_dst), 32'(v.dst));
            check("hold_data", bus.wb_data, v.want);
            @(posedge clk); #1;
            if (i == v.hold - 1) bus.wb_ready = 1'b1;
            @(negedge clk);
        end
        check("stall_done", 32'(bus.stall), 1);
        @(negedge clk);
        check("wb_cleared", 32'(bus.wb_valid), 0);
        check("ready_after_hs", 32'(bus.req_ready), 1);
        check("handshakes", hs - h0, 1);
        check("clo_pulses", clo_hi - c0, 32'(v.clo));
        check("clz_pulses", clz_hi - z0, 32'(v.clz && !v.clo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0;
        int uf0;
        int to0;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_clo = 1'b0;
        bus.req_clz = 1'b0;
        bus.req_operand = '0;
        bus.req_dst = '0;
        bus.wb_ready = 1'b1;
        vecs[0] = '{1'b0, 1'b1, 32'h0000FFFF, 5'd7, 3, 0, 32'd16};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFFFFFF, 5'd1, 5, 0, 32'd32};
        vecs[2] = '{1'b0, 1'b1, 32'h00000000, 5'd2, 1, 0, 32'd32};
        vecs[3] = '{1'b1, 1'b0, 32'h7FFFFFFF, 5'd3, 2, 5, 32'd0};
        vecs[4] = '{1'b1, 1'b1, 32'hC0000000, 5'd4, 4, 0, 32'd2};
        vecs[5] = '{1'b0, 1'b0, 32'h12345678, 5'd5, 2, 0, 32'd0};
        vecs[6] = '{1'b0, 1'b1, 32'h00000001, 5'd6, 6, 1, 32'd31};
        vecs[7] = '{1'b1, 1'b0, 32'hF0000000, 5'd30, 2, 0, 32'd4};

        repeat (2) @(negedge clk);
        check("rst_unit_flush", 32'(bus.unit_flush), 1);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_stall", 32'(bus.stall), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(bus.req_ready), 1);
        check("idle_unit_flush", 32'(bus.unit_flush), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        lat_cfg = 3;
        bus.wb_ready = 1'b1;
        h0 = hs;
        issue(1'b1, 1'b0, 32'hFFFFFFFF, 5'd11, 32'd32, 1'b1);
        wait_wb();
        bus.req_valid = 1'b1;
        bus.req_clo = 1'b0;
        bus.req_clz = 1'b1;
        bus.req_operand = '0;
        bus.req_dst = 5'd12;
        #1;
        check("b2b_ready_low", 32'(bus.req_ready), 0);
        check("b2b_stall", 32'(bus.stall), 1);
        @(negedge clk);
        check("b2b_ready_next", 32'(bus.req_ready), 1);
        q.push_back('{5'd12, 32'd32});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_wb();
        @(negedge clk);
        check("b2b_handshakes", hs - h0, 2);
        check("b2b_queue", q.size(), 0);

        lat_cfg = 20;
        to0 = to_hi;
        h0 = hs;
        issue(1'b0, 1'b1, 32'h00000001, 5'd13, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_unit_flush", 32'(bus.unit_flush), 1);
        check("flush_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_ready_next", 32'(bus.req_ready), 1);
        check("flush_no_wb", 32'(bus.wb_valid), 0);
        check("flush_no_timeout", to_hi - to0, 0);
        check("flush_no_handshake", hs - h0, 0);
        run_vec('{1'b1, 1'b0, 32'hF0000000, 5'd14, 2, 0, 32'd4});

        hang = 1'b1;
        to0 = to_hi;
        h0 = hs;
        issue(1'b0, 1'b1, 32'h00FF0000, 5'd16, 32'd0, 1'b0);
        uf0 = uf_hi;
        begin
            int n = 1;
            @(negedge clk);
            while (!bus.timeout_err && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycle", n, 3 + MW);
        end
        check("timeout_unit_flush", 32'(bus.unit_flush), 1);
        check("timeout_no_wb", 32'(bus.wb_valid), 0);
        check("timeout_idle", 32'(bus.req_ready), 1);
        hang = 1'b0;
        @(negedge clk);
        check("timeout_pulse_end", 32'(bus.timeout_err), 0);
        check("timeout_pulses", to_hi - to0, 1);
        check("timeout_flush_cycles", uf_hi - uf0, 1);
        check("timeout_no_handshake", hs - h0, 0);

        hang = 1'b1;
        issue(1'b1, 1'b0, 32'h80000000, 5'd15, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_unit_flush", 32'(bus.unit_flush), 1);
        check("rst_wait_req_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("rst_wait_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_wait_wb_dst", 32'(bus.wb_dst), 0);
        check("rst_wait_wb_data", bus.wb_data, 0);
        check("rst_wait_clo", 32'(bus.unit_clo), 0);
        check("rst_wait_clz", 32'(bus.unit_clz), 0);
        check("rst_wait_timeout", 32'(bus.timeout_err), 0);
        check("rst_wait_stall", 32'(bus.stall), 0);
        hang = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_wait_ready", 32'(bus.req_ready), 1);
        run_vec(vecs[0]);

        check("final_queue", q.size(), 0);
        check("final_timeouts", to_hi, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
